// File: rtl/fp_pkg.sv
// fp_pkg: shared types and widths for the floating-point adder sequencer
package fp_pkg;
  localparam int EXP_W  = 6;
  localparam int MAN_W  = 25;
  localparam int DATA_W = 1 + EXP_W + MAN_W;
  typedef enum logic [3:0] {
    ST_EXACT   = 4'd0,
    ST_OVF     = 4'd1,
    ST_UNF     = 4'd2,
    ST_INEXACT = 4'd3,
    ST_TIMEOUT = 4'd4
  } status_e;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    RESPOND = 2'd3
  } state_e;
endpackage

// File: rtl/rr_arbiter_2.sv
// rr_arbiter_2: combinational two-way round-robin pick favouring the pointer
module rr_arbiter_2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt,
  output logic       gnt_id
);
  // pointer side wins when it asks, otherwise the other side
  always_comb begin
    gnt_id = req[ptr] ? ptr : ~ptr;
    gnt    = req[gnt_id] ? (2'b01 << gnt_id) : 2'b00;
  end
endmodule

// File: rtl/fp_add_arbiter.sv
// fp_add_arbiter: shares one floating-point adder between two requesters
module fp_add_arbiter
  import fp_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                   clock_100kHz,
  input  logic                   reset,
  input  logic [1:0]             req_valid,
  output logic [1:0]             req_ready,
  input  logic [1:0][DATA_W-1:0] req_op_a,
  input  logic [1:0][DATA_W-1:0] req_op_b,
  output logic [1:0]             rsp_valid,
  input  logic [1:0]             rsp_ready,
  output logic [DATA_W-1:0]      rsp_data,
  output logic [3:0]             rsp_status,
  output logic                   fpu_start,
  output logic [DATA_W-1:0]      fpu_op_a,
  output logic [DATA_W-1:0]      fpu_op_b,
  input  logic                   fpu_done,
  input  logic [DATA_W-1:0]      fpu_result,
  input  logic [3:0]             fpu_status,
  output logic                   busy,
  output logic                   grant_id
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  state_e            state_q, state_d;
  logic              ptr_q, ptr_d;
  logic              grant_q, grant_d;
  logic [DATA_W-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [3:0]        status_q, status_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [1:0]        gnt;
  logic              gnt_id;
  rr_arbiter_2 u_arb (
    .req    (req_valid),
    .ptr    (ptr_q),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );
  assign req_ready  = (state_q == IDLE) ? gnt : 2'b00;
  assign rsp_valid  = (state_q == RESPOND) ? (2'b01 << grant_q) : 2'b00;
  assign fpu_start  = state_q == ISSUE;
  assign busy       = state_q != IDLE;
  assign grant_id   = grant_q;
  assign fpu_op_a   = op_a_q;
  assign fpu_op_b   = op_b_q;
  assign rsp_data   = data_q;
  assign rsp_status = status_q;
  // sequencing: accept, launch, wait for done or timeout, hold response until taken
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    grant_d  = grant_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    data_d   = data_q;
    status_d = status_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: if (|gnt) begin
        op_a_d  = req_op_a[gnt_id];
        op_b_d  = req_op_b[gnt_id];
        grant_d = gnt_id;
        state_d = ISSUE;
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: if (fpu_done) begin
        data_d   = fpu_result;
        status_d = fpu_status;
        state_d  = RESPOND;
      end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
        data_d   = '0;
        status_d = ST_TIMEOUT;
        state_d  = RESPOND;
      end else cnt_d = cnt_q + CW'(1);
      RESPOND: if (rsp_ready[grant_q]) begin
        ptr_d   = ~grant_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // state and datapath registers; reset discards any in-flight operation
  always_ff @(posedge clock_100kHz or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      ptr_q    <= 1'b0;
      grant_q  <= 1'b0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      data_q   <= '0;
      status_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      grant_q  <= grant_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      data_q   <= data_d;
      status_q <= status_d;
      cnt_q    <= cnt_d;
    end
  end
endmodule

// File: tb/tb_fp_add_arbiter.sv
// tb_fp_add_arbiter: randomized and directed checks against a transaction-level model
module tb_fp_add_arbiter;
  localparam int TO = 64;
  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [1:0]        req_valid = '0, req_ready, rsp_valid, rsp_ready = '0;
  logic [1:0][31:0]  req_op_a = '0, req_op_b = '0;
  logic [31:0]       rsp_data, fpu_op_a, fpu_op_b, fpu_result = '0;
  logic [3:0]        rsp_status, fpu_status = '0;
  logic              fpu_start, fpu_done = 1'b0, busy, grant_id;
  logic              viol = 1'b0;
  int                errs = 0, checks = 0, ptr_m = 0;

  fp_add_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clock_100kHz(clk), .reset(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op_a(req_op_a), .req_op_b(req_op_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_status(rsp_status),
    .fpu_start(fpu_start), .fpu_op_a(fpu_op_a), .fpu_op_b(fpu_op_b),
    .fpu_done(fpu_done), .fpu_result(fpu_result), .fpu_status(fpu_status),
    .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (req_ready == 2'b11 || rsp_valid == 2'b11) viol <= 1'b1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One transaction: the adder stand-in answers lat cycles after start (lat outside 1..TO means no answer in time),
  // and the winner holds off rsp_ready for bp cycles.
  task automatic do_op(input logic [1:0] mask, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] res, input logic [3:0] st, input int lat, input int bp);
    int win, ex;
    logic [31:0] ea, eb, ed;
    logic [3:0] es;
    logic [1:0] oh;
    logic bad;
    req_op_a[0] = a;  req_op_b[0] = b;
    req_op_a[1] = ~a; req_op_b[1] = b ^ 32'h5a5a_5a5a;
    req_valid = mask; rsp_ready = 2'b00;
    #1;
    win = mask[ptr_m] ? ptr_m : 1 - ptr_m;
    oh  = (win == 1) ? 2'b10 : 2'b01;
    ea  = (win == 1) ? ~a : a;
    eb  = (win == 1) ? (b ^ 32'h5a5a_5a5a) : b;
    ex  = (lat >= 1 && lat <= TO) ? lat + 1 : TO + 1;
    ed  = (lat >= 1 && lat <= TO) ? res : 32'h0;
    es  = (lat >= 1 && lat <= TO) ? st : 4'd4;
    chk("req_ready", {30'b0, req_ready}, {30'b0, oh});
    tick();
    chk("fpu_start", {31'b0, fpu_start}, 32'd1);
    chk("fpu_op_a", fpu_op_a, ea);
    chk("fpu_op_b", fpu_op_b, eb);
    chk("grant_id", {31'b0, grant_id}, win);
    bad = 1'b0;
    for (int j = 1; j <= ex; j++) begin
      tick();
      fpu_done   = (j == lat);
      fpu_result = (j == lat) ? res : $urandom;
      fpu_status = (j == lat) ? st : 4'($urandom_range(0, 15));
      if (j < ex) bad |= (rsp_valid != 2'b00) || (req_ready != 2'b00) || fpu_start;
    end
    chk("wait_quiet", {31'b0, bad}, 32'd0);
    chk("rsp_valid", {30'b0, rsp_valid}, {30'b0, oh});
    chk("rsp_data", rsp_data, ed);
    chk("rsp_status", {28'b0, rsp_status}, {28'b0, es});
    chk("busy_rsp", {31'b0, busy}, 32'd1);
    chk("op_hold", fpu_op_a, ea);
    bad = 1'b0;
    rsp_ready = (bp > 0) ? ~oh : 2'b00;
    for (int k = 0; k < bp; k++) begin
      tick();
      fpu_done = (k == 0); fpu_result = 32'hdead_beef; fpu_status = 4'h1;
      bad |= (rsp_valid != oh) || (rsp_data != ed) || (rsp_status != es) || (req_ready != 2'b00) || fpu_start;
    end
    if (bp > 0) chk("backpressure_hold", {31'b0, bad}, 32'd0);
    rsp_ready = oh;
    tick();
    fpu_done = 1'b0; rsp_ready = 2'b00;
    chk("idle_busy", {31'b0, busy}, 32'd0);
    chk("idle_rsp", {30'b0, rsp_valid}, 32'd0);
    ptr_m = 1 - win;
  endtask

  initial begin
    repeat (2) tick();
    chk("rst_ctrl", {26'b0, req_ready, rsp_valid, fpu_start, busy}, 32'd0);
    chk("rst_misc", {27'b0, rsp_status, grant_id}, 32'd0);
    chk("rst_data", rsp_data | fpu_op_a | fpu_op_b, 32'd0);
    rst_n = 1'b1;
    tick();
    do_op(2'b01, 32'h4000_0000, 32'h4000_0000, 32'h4200_0000, 4'd0, 5, 0);
    for (int i = 0; i < 4; i++)
      do_op(2'b11, $urandom, $urandom, $urandom, 4'($urandom_range(0, 3)), $urandom_range(1, 10), 0);
    do_op(2'b01, $urandom, $urandom, 32'hffff_ffff, 4'd1, TO + 1, 2);
    do_op(2'b10, $urandom, $urandom, 32'hcafe_0001, 4'd2, 3, 10);
    do_op(2'b11, $urandom, $urandom, 32'h1234_5678, 4'd3, TO, 0);
    req_valid = 2'b01; #1;
    tick();
    repeat (3) tick();
    rst_n = 1'b0; req_valid = 2'b00;
    #1;
    chk("mid_rst_ctrl", {26'b0, req_ready, rsp_valid, fpu_start, busy}, 32'd0);
    chk("mid_rst_misc", {27'b0, rsp_status, grant_id}, 32'd0);
    chk("mid_rst_data", rsp_data | fpu_op_a | fpu_op_b, 32'd0);
    ptr_m = 0;
    tick();
    rst_n = 1'b1;
    tick();
    fpu_done = 1'b1; fpu_result = 32'h0bad_0bad; fpu_status = 4'h2;
    tick();
    fpu_done = 1'b0;
    tick();
    chk("stray_busy", {31'b0, busy}, 32'd0);
    chk("stray_rsp", {30'b0, rsp_valid}, 32'd0);
    do_op(2'b10, $urandom, $urandom, 32'h7777_0000, 4'd0, 4, 1);
    for (int i = 0; i < 20; i++)
      do_op(2'($urandom_range(1, 3)), $urandom, $urandom, $urandom, 4'($urandom_range(0, 3)),
            $urandom_range(1, 70), $urandom_range(0, 3));
    chk("onehot_ready_valid", {31'b0, viol}, 32'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
